// File: rtl/uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : CPU-bus mapped 8N1 serial transmitter with a byte FIFO,
//            programmable bit period and a pollable status register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLK_DIV = 104,
    parameter int FIFO_AW = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       select,
    input  logic       reg_addr,
    input  logic       write_enable,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       tx,
    output logic       busy
);

    localparam int c_CW = FIFO_AW + 1;
    localparam logic [c_CW-1:0] c_FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [15:0]     c_BAUD_LAST  = 16'(CLK_DIV - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    logic [7:0]         r_mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0]    r_count;
    logic               r_ovf;
    logic [1:0]         r_state;
    logic [15:0]        r_baud;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               r_tx;
    logic               r_busy;

    logic               w_full;
    logic               w_empty;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_ovf_clr;
    logic               w_baud_done;
    logic [7:0]         w_head;
    logic [c_CW-1:0]    w_count_nxt;
    logic [1:0]         w_state_nxt;
    logic [15:0]        w_baud_nxt;
    logic [2:0]         w_bit_nxt;
    logic [7:0]         w_shift_nxt;
    logic               w_tx_nxt;
    logic               w_tx_idle;
    logic [4:0]         w_count_sat;

    assign w_full      = (r_count == c_FULL_COUNT);
    assign w_empty     = (r_count == '0);
    assign w_push_req  = select & write_enable & ~reg_addr;
    // Fullness is judged on the pre-edge count, so a push racing a pop while full is dropped.
    assign w_push      = w_push_req & ~w_full;
    assign w_ovf_clr   = select & write_enable & reg_addr;
    assign w_baud_done = (r_baud == c_BAUD_LAST);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_tx_idle   = (r_state == c_ST_IDLE) & w_empty;

    // Frame sequencing: next state, bit timing, shift register and line level.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + 16'd1;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_baud_nxt = '0;
                w_tx_nxt   = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_state_nxt = c_ST_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            c_ST_START: begin
                if (w_baud_done) begin
                    w_state_nxt = c_ST_DATA;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end
            end
            c_ST_DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = c_ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                        w_bit_nxt   = r_bit_cnt + 3'd1;
                    end
                end
            end
            c_ST_STOP: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_state_nxt = c_ST_START;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_baud_nxt  = '0;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // FIFO occupancy after this edge's push and pop.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CW'(1);
            2'b01:   w_count_nxt = r_count - c_CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // FIFO pointers, count and sticky overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            r_count <= w_count_nxt;
            if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end else if (w_push_req && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Transmitter state, counters, line driver and busy flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_ST_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= (w_count_nxt != '0) | (w_state_nxt != c_ST_IDLE);
        end
    end

    // The count field in the status register is 5 bits wide and saturates for deep FIFOs.
    generate
        if (c_CW > 5) begin : g_cnt_sat
            assign w_count_sat = (r_count > c_CW'(31)) ? 5'd31 : r_count[4:0];
        end else begin : g_cnt_ext
            assign w_count_sat = 5'(r_count);
        end
    endgenerate

    assign data_out = !select  ? 8'h00 :
                      reg_addr ? {3'b000, w_count_sat} :
                                 {5'b00000, r_ovf, w_full, w_tx_idle};
    assign tx       = r_tx;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Randomised scoreboard bench for uart_tx against a cycle-level
//            behavioural model of the FIFO and frame scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int DIV   = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * DIV;

    logic       clk          = 1'b0;
    logic       reset_n      = 1'b0;
    logic       select       = 1'b0;
    logic       reg_addr     = 1'b0;
    logic       write_enable = 1'b0;
    logic [7:0] data_in      = 8'h00;
    logic [7:0] data_out;
    logic       tx;
    logic       busy;

    always #5 clk = ~clk;

    uart_tx #(.CLK_DIV(DIV), .FIFO_AW(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .select       (select),
        .reg_addr     (reg_addr),
        .write_enable (write_enable),
        .data_in      (data_in),
        .data_out     (data_out),
        .tx           (tx),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // cyc = number of rising edges processed so far; edge index e is the edge that makes cyc e+1.
    int         cyc        = 0;
    int         m_count    = 0;
    bit         m_ovf      = 1'b0;
    bit         m_have_pop = 1'b0;
    int         m_last_pop = 0;
    logic [7:0] exp_q[$];   // accepted bytes in transmit order
    int         pop_q[$];   // edge at which each frame's start bit should begin
    int         frames_done = 0;

    // Model: a frame starts on any edge with data queued once the previous frame's 10 bit times are over.
    always @(posedge clk) begin : model
        int pre;
        bit do_pop;
        if (!reset_n) begin
            m_count    = 0;
            m_ovf      = 1'b0;
            m_have_pop = 1'b0;
            exp_q.delete();
            pop_q.delete();
        end else begin
            pre    = m_count;
            do_pop = (pre > 0) && (!m_have_pop || cyc >= m_last_pop + FRAME);
            if (do_pop) begin
                m_have_pop = 1'b1;
                m_last_pop = cyc;
                pop_q.push_back(cyc);
                m_count--;
            end
            if (select && write_enable && !reg_addr) begin
                if (pre < DEPTH) begin
                    exp_q.push_back(data_in);
                    m_count++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (select && write_enable && reg_addr) m_ovf = 1'b0;
        end
        cyc++;
    end

    // ---------------- monitor ----------------
    logic       prev_tx  = 1'b1;
    bit         in_frame = 1'b0;
    int         pos      = 0;
    int         f_edge   = 0;
    bit         f_err    = 1'b0;
    logic [7:0] f_byte   = 8'h00;

    // Monitor: checks status/busy every cycle and decodes serial frames into the scoreboard.
    always @(negedge clk) begin : monitor
        int         e;
        int         slot;
        bit         idle;
        logic [7:0] exp_do;
        e = cyc - 1;
        if (!reset_n) begin
            in_frame = 1'b0;
            check("rst_tx", tx, 1);
            check("rst_busy", busy, 0);
            check("rst_data_out", data_out, select ? (reg_addr ? 8'h00 : 8'h01) : 8'h00);
        end else begin
            idle = !m_have_pop || (e >= m_last_pop + FRAME);
            check("busy", busy, ((m_count != 0) || !idle) ? 1 : 0);
            if (!select)       exp_do = 8'h00;
            else if (reg_addr) exp_do = 8'(m_count);
            else               exp_do = {5'b0, m_ovf, (m_count == DEPTH), ((m_count == 0) && idle)};
            check("data_out", data_out, exp_do);

            if (!in_frame) begin
                if (prev_tx === 1'b1 && tx === 1'b0) begin
                    in_frame = 1'b1;
                    pos      = 0;
                    f_edge   = e;
                    f_err    = 1'b0;
                    f_byte   = 8'h00;
                end else begin
                    check("tx_idle_level", tx, 1);
                end
            end
            if (in_frame) begin
                slot = pos / DIV;
                if (slot == 0) begin
                    if (tx !== 1'b0) f_err = 1'b1;
                end else if (slot == 9) begin
                    if (tx !== 1'b1) f_err = 1'b1;
                end else if (pos % DIV == 0) begin
                    f_byte[slot-1] = tx;
                end else if (tx !== f_byte[slot-1]) begin
                    f_err = 1'b1;
                end
                if (pos == FRAME - 1) begin
                    in_frame = 1'b0;
                    frames_done++;
                    check("frame_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                    if (exp_q.size() > 0) check("frame_byte", f_byte, exp_q.pop_front());
                    if (pop_q.size() > 0) check("frame_start_edge", f_edge, pop_q.pop_front());
                    check("frame_shape", f_err, 0);
                end
                pos++;
            end
        end
        prev_tx = tx;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        select       = 1'b0;
        write_enable = 1'b0;
        reg_addr     = 1'b0;
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        select       = 1'b1;
        write_enable = 1'b1;
        reg_addr     = a;
        data_in      = d;
        tick();
        bus_idle();
    endtask

    task automatic rd(input logic a, input logic [7:0] exp, input string name);
        select       = 1'b1;
        write_enable = 1'b0;
        reg_addr     = a;
        @(negedge clk);
        check(name, data_out, exp);
        tick();
        bus_idle();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", (n < budget) ? 1 : 0, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int f0;
        int w0;
        bus_idle();
        reset_n = 1'b0;
        repeat (3) tick();
        rd(1'b0, 8'h01, "reset_status_sel");
        @(negedge clk);
        check("reset_status_unsel", data_out, 8'h00);
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();

        // Single byte
        f0 = frames_done;
        wr(1'b0, 8'hA5);
        wait_drain(200);
        check("single_frames", frames_done - f0, 1);

        // Back-to-back frames
        f0 = frames_done;
        select = 1'b1; write_enable = 1'b1; reg_addr = 1'b0;
        data_in = 8'h00; tick();
        data_in = 8'hFF; tick();
        bus_idle();
        wait_drain(300);
        check("b2b_frames", frames_done - f0, 2);

        // Overflow: 18 consecutive writes
        f0 = frames_done;
        select = 1'b1; write_enable = 1'b1; reg_addr = 1'b0;
        for (int i = 0; i < 18; i++) begin
            data_in = 8'($urandom);
            tick();
        end
        bus_idle();
        rd(1'b0, 8'h06, "ovf_status");
        rd(1'b1, 8'd16, "ovf_count");
        wr(1'b1, 8'hFF);
        rd(1'b0, 8'h02, "ovf_cleared");
        wait_drain(17 * FRAME + 200);
        check("ovf_frames", frames_done - f0, 17);

        // Push while full on the exact STOP->START pop edge
        f0 = frames_done;
        w0 = cyc;
        select = 1'b1; write_enable = 1'b1; reg_addr = 1'b0;
        for (int i = 0; i < 17; i++) begin
            data_in = 8'($urandom);
            tick();
        end
        bus_idle();
        rd(1'b1, 8'd16, "pushpop_full_count");
        while (cyc < w0 + 1 + FRAME) tick();
        wr(1'b0, 8'h3C);
        rd(1'b1, 8'd15, "pushpop_count");
        rd(1'b0, 8'h04, "pushpop_status");
        wr(1'b1, 8'h00);
        wait_drain(17 * FRAME + 200);
        check("pushpop_frames", frames_done - f0, 17);

        // Randomised bus traffic
        for (int i = 0; i < 600; i++) begin
            select       = ($urandom_range(0, 3) != 0);
            write_enable = ($urandom_range(0, 5) == 0);
            reg_addr     = ($urandom_range(0, 9) == 0);
            data_in      = 8'($urandom);
            tick();
        end
        bus_idle();
        wr(1'b1, 8'h00);
        wait_drain(DEPTH * FRAME + 200);

        // Reset during data bit 3 of 8'h55 (bit 3 is 0)
        f0 = frames_done;
        w0 = cyc;
        select = 1'b1; write_enable = 1'b1; reg_addr = 1'b0;
        data_in = 8'h55; tick();
        data_in = 8'hC3; tick();
        bus_idle();
        while (cyc < w0 + 2 + 4 * DIV) tick();
        check("pre_reset_tx", tx, 0);
        reset_n = 1'b0;
        #1;
        check("async_reset_tx", tx, 1);
        check("async_reset_busy", busy, 0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (100) tick();
        check("post_reset_busy", busy, 0);
        check("post_reset_frames", frames_done - f0, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Memory-mapped serial transmitter on the CPU bus, peer of the IO and VDP write ports. It accepts bytes written by the 6502 into a small FIFO and serialises them as 8N1 frames on a single TX pin, with a programmable bit period. A status register lets firmware poll FIFO fullness, transmitter idle and a sticky overflow flag. Read data is zero when the block is not selected, so its output can be OR-merged into the CPU data-in mux.

## Interface
- CLK_DIV, 104: clock cycles per serial bit; legal range 2..65535.
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW entries.

- clk  input  1  CPU clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- select  input  1  address-decode hit for this block (driven from addr upper bits).
- reg_addr  input  1  register select (CPU addr[0]).
- write_enable  input  1  CPU writing this cycle.
- data_in  input  8  CPU write data.
- data_out  output  8  status read data, combinational; 8'h00 when select=0.
- tx  output  1  serial line, idle high, registered.
- busy  output  1  high when FIFO non-empty or FSM not IDLE, registered.

## Operation
- Register map:
  - reg_addr=0, write: push data_in into FIFO.
  - reg_addr=0, read: {5'b0, overflow, fifo_full, tx_idle}.
  - reg_addr=1, write: clear overflow (data ignored).
  - reg_addr=1, read: {3'b0, fifo_count} (count saturates at 5 bits; the full count is 16 at default depth).
- A write is any rising edge with select & write_enable; one push per edge.
- FIFO: circular buffer, FIFO_AW-bit read/write pointers plus an (FIFO_AW+1)-bit count. Full = count == 2**FIFO_AW; empty = count == 0.
- A push while full is not enqueued. It sets overflow = 1, which stays set until cleared. This uses the pre-edge count, so a push coinciding with a pop while full is still dropped.
- Simultaneous push and pop: count unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty, pop the head into an 8-bit shift register, go to START, tx=0.
  - START: hold CLK_DIV cycles, then DATA with tx=shift[0].
  - DATA: each CLK_DIV cycles shift right, increment a 3-bit bit counter. After bit 7 completes, go to STOP with tx=1.
  - STOP: hold CLK_DIV cycles. Then, if the FIFO is non-empty, pop and go directly to START (tx=0, no idle gap); else go to IDLE.
- Baud counter: counts 0..CLK_DIV-1 and reloads to 0 on every state change.
- tx_idle = (state==IDLE) & FIFO empty.

## Timing
- Reset values: tx=1, busy=0, state=IDLE, pointers/count=0, overflow=0, shift=0, baud and bit counters=0. data_out follows the reset state combinationally (status 8'h01 if selected).
- Reset asserted mid-frame aborts immediately: tx returns to 1 asynchronously and FIFO contents are discarded.
- Write to empty FIFO at edge N → count=1 after N. At edge N+1 the FSM pops and tx falls; busy rises at edge N.
- Start bit low for exactly CLK_DIV cycles. Each data bit lasts CLK_DIV cycles, LSB first. Stop bit lasts CLK_DIV cycles. A frame is 10·CLK_DIV cycles from the tx falling edge.
- Back-to-back frames: the next start bit begins on the edge ending the previous stop bit.
- busy falls on the edge the FSM enters IDLE with the FIFO empty.
- fifo_full and overflow are visible in data_out the cycle after the causing edge.

## Test plan
- Reset: hold reset_n=0 → tx=1, busy=0; select=1, reg_addr=0 reads 8'h01; select=0 reads 8'h00.
- Single byte, CLK_DIV=4: write 8'hA5 → tx low 4 cycles starting 1 cycle after the write, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, high 4 cycles, busy low after 40 cycles.
- Back-to-back: write 8'h00 then 8'h FF on consecutive cycles → two frames, 80 cycles total at CLK_DIV=4, no idle gap between the first stop bit and the second start bit.
- Overflow: with CLK_DIV=1000, write 18 bytes in consecutive cycles.
  - After the first pop, 16 are held and status bit 1 (full) = 1.
  - Dropped writes set bit 2 = 1.
  - A reg_addr=1 write clears bit 2.
  - Exactly 17 frames are transmitted.
- Full push+pop: fill the FIFO to 16, then write on the exact cycle of the STOP→START pop → write dropped, overflow=1, count=15 after the edge.
- Reset mid-frame: assert reset_n during DATA bit 3 → tx=1 asynchronously; after release, no further frames and busy=0.
